// File: rtl/serializador_tx.sv
// serializador_tx: parallel-to-serial transmitter for the Registrador datapath.
// Sends a byte as a UART-style frame, LSB first: start(0), DATA_W data bits,
// optional even parity bit, stop(1). Each serial bit is held for CLKS_PER_BIT clocks.
// Optional feature macro: SERIALIZADOR_PARITY_EN inserts the parity bit.
// All outputs come straight from flops.
module serializador_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] D,
  input  logic              Valid,
  output logic              Ready,
  output logic              Tx,
  output logic              Busy,
  output logic              Done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] shreg_d;
  logic              tx_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic              cntWrap;

`ifdef SERIALIZADOR_PARITY_EN
  logic              parity_q;
`endif

  // Cycle counter wraps at the end of every serial bit; the shift register
  // drops one data bit per wrap so the next bit is always at position 0.
  assign cntWrap = (cnt_q == CNT_LAST);
  assign cnt_d   = cntWrap ? '0 : cnt_q + CNT_W'(1);
  assign shreg_d = shreg_q >> 1;

  // Frame sequencer: state, counters, shift register and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIALIZADOR_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q   <= '0;
          idx_q   <= '0;
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          if (Valid) begin
            shreg_q  <= D;
`ifdef SERIALIZADOR_PARITY_EN
            parity_q <= ^D;
`endif
            state_q  <= START;
            tx_q     <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
          end
        end

        START: begin
          cnt_q <= cnt_d;
          if (cntWrap) begin
            state_q <= DATA;
            tx_q    <= shreg_q[0];
          end
        end

        DATA: begin
          cnt_q <= cnt_d;
          if (cntWrap) begin
            shreg_q <= shreg_d;
            if (idx_q == IDX_LAST) begin
              idx_q   <= '0;
`ifdef SERIALIZADOR_PARITY_EN
              state_q <= PARITY;
              tx_q    <= parity_q;
`else
              state_q <= STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              idx_q <= idx_q + IDX_W'(1);
              tx_q  <= shreg_d[0];
            end
          end
        end

`ifdef SERIALIZADOR_PARITY_EN
        PARITY: begin
          cnt_q <= cnt_d;
          if (cntWrap) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
        end
`endif

        STOP: begin
          cnt_q <= cnt_d;
          tx_q  <= 1'b1;
          if (cntWrap) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          idx_q   <= '0;
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Tx    = tx_q;
  assign Ready = ready_q;
  assign Busy  = busy_q;
  assign Done  = done_q;

endmodule

// File: tb/tb_serializador_tx.sv
// Testbench for serializador_tx (DATA_W=8, CLKS_PER_BIT=4).
// Stimulus queues the expected frames; a monitor compares the line cycle by cycle.
module tb_serializador_tx;

  localparam int DATA_W = 8;
  localparam int CPB    = 4;
`ifdef SERIALIZADOR_PARITY_EN
  localparam int NSLOTS = DATA_W + 3;
`else
  localparam int NSLOTS = DATA_W + 2;
`endif
  localparam int FRAME_CYC = NSLOTS * CPB;

  typedef struct {
    logic [7:0] data;
    int         startCycle;
  } frame_t;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Valid;
  logic [7:0] D;
  logic       Ready;
  logic       Tx;
  logic       Busy;
  logic       Done;

  frame_t expQ[$];
  int     checks = 0;
  int     errors = 0;
  int     cycleCount = 0;

  serializador_tx #(
    .DATA_W(DATA_W),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .D(D),
    .Valid(Valid),
    .Ready(Ready),
    .Tx(Tx),
    .Busy(Busy),
    .Done(Done)
  );

  // Free-running clock and cycle index used to time expected frames.
  always #5 Clk = ~Clk;

  always @(posedge Clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", name, cycleCount, actual, expected);
    end
  endtask

  // Reference: the line level for cycle k of a frame carrying byte b.
  function automatic logic expectedTx(input logic [7:0] b, input int k);
    int slot;
    slot = k / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= DATA_W) return b[slot-1];
`ifdef SERIALIZADOR_PARITY_EN
    if (slot == DATA_W + 1) return ^b;
`endif
    return 1'b1;
  endfunction

  // Monitor: compares {Tx,Ready,Busy,Done} every cycle against the queued frames.
  logic       inFrame = 1'b0;
  logic       doneExpected = 1'b0;
  int         frameCyc = 0;
  frame_t     cur;
  logic [3:0] monExp;
  string      monName;

  always @(negedge Clk) begin
    if (Reset === 1'b1) begin
      inFrame      = 1'b0;
      doneExpected = 1'b0;
    end else begin
      if (!inFrame && expQ.size() > 0 && expQ[0].startCycle == cycleCount) begin
        cur      = expQ.pop_front();
        inFrame  = 1'b1;
        frameCyc = 0;
      end
      if (inFrame) begin
        monExp  = {expectedTx(cur.data, frameCyc), 3'b010};
        monName = $sformatf("frame_%02h_c%0d", cur.data, frameCyc);
        frameCyc++;
        if (frameCyc == FRAME_CYC) begin
          inFrame      = 1'b0;
          doneExpected = 1'b1;
        end
      end else if (doneExpected) begin
        monExp       = 4'b1101;
        monName      = "done";
        doneExpected = 1'b0;
      end else begin
        monExp  = 4'b1100;
        monName = "idle";
      end
      checkOutput(monName, {4'b0, Tx, Ready, Busy, Done}, {4'b0, monExp});
    end
  end

  task automatic waitReady();
    int waited;
    waited = 0;
    while (Ready !== 1'b1 && waited < FRAME_CYC + 10) begin
      @(posedge Clk);
      #1;
      waited++;
    end
    if (Ready !== 1'b1) checkOutput("readyTimeout", {7'b0, Ready}, 8'd1);
  endtask

  // One-cycle Valid pulse once the block is ready; expected frame starts next cycle.
  task automatic applyStimulus(input logic [7:0] b);
    frame_t f;
    waitReady();
    D            = b;
    Valid        = 1'b1;
    f.data       = b;
    f.startCycle = cycleCount + 1;
    expQ.push_back(f);
    @(posedge Clk);
    #1;
    Valid = 1'b0;
  endtask

  initial begin
    frame_t f;
    int     gap;
    int     waited;
    Reset = 1'b1;
    Valid = 1'b0;
    D     = 8'h00;

    // Reset held two cycles; outputs at idle right after the first reset edge.
    @(posedge Clk);
    #1;
    checkOutput("resetState", {4'b0, Tx, Ready, Busy, Done}, 8'b0000_1100);
    Valid = 1'b1;
    D     = 8'hEE;
    @(posedge Clk);
    #1;
    checkOutput("validDuringReset", {4'b0, Tx, Ready, Busy, Done}, 8'b0000_1100);
    Valid = 1'b0;
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;

    // Basic frame.
    applyStimulus(8'hA5);
    applyStimulus(8'h01);

    // Back-to-back: Valid held through the Done cycle, D switched to the next byte.
    waitReady();
    D            = 8'h3C;
    Valid        = 1'b1;
    f.data       = 8'h3C;
    f.startCycle = cycleCount + 1;
    expQ.push_back(f);
    @(posedge Clk);
    #1;
    repeat (FRAME_CYC) @(posedge Clk);
    #1;
    D            = 8'hC3;
    f.data       = 8'hC3;
    f.startCycle = cycleCount + 1;
    expQ.push_back(f);
    @(posedge Clk);
    #1;
    Valid = 1'b0;

    // Valid pulse with 8'hFF in the middle of an all-zero frame must be ignored.
    applyStimulus(8'h00);
    repeat (19) @(posedge Clk);
    #1;
    D     = 8'hFF;
    Valid = 1'b1;
    @(posedge Clk);
    #1;
    Valid = 1'b0;

    // Reset during cycle 15 of a frame aborts it without Done.
    applyStimulus(8'hA5);
    repeat (14) @(posedge Clk);
    #1;
    Reset = 1'b1;
    expQ.delete();
    @(posedge Clk);
    #1;
    checkOutput("resetMidFrame", {4'b0, Tx, Ready, Busy, Done}, 8'b0000_1100);
    Reset = 1'b0;
    applyStimulus(8'h5A);

    // Random bytes with random idle gaps (gap 0 lands on the Done cycle).
    for (int i = 0; i < 16; i++) begin
      gap = $urandom_range(0, 3);
      waitReady();
      repeat (gap) begin
        @(posedge Clk);
        #1;
      end
      applyStimulus(8'($urandom));
    end

    // Drain outstanding frames within a bounded time.
    waited = 0;
    while ((expQ.size() > 0 || inFrame || doneExpected) && waited < 3 * FRAME_CYC) begin
      @(posedge Clk);
      #1;
      waited++;
    end
    checkOutput("drain", 8'(expQ.size()) | {7'b0, inFrame}, 8'd0);
    repeat (3) @(posedge Clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
